cpu_datapath: RTL and testbench

- 32-bit single-bus CPU datapath with register file R0–R15, HI, LO, Y, Z (64-bit), PC, IR, MAR and MDR, plus a combinational ALU.
- Every register load and bus-driver select comes from an external control unit (or bench) through one-hot-style vectors.
- The block holds no instruction-decode logic. It sits under the CPU top, between the control unit and memory.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/cpu_alu.sv | 63 ++++++
 rtl/cpu_datapath.sv | 100 ++++++++++
 tb/tb_cpu_datapath.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the single-bus CPU datapath: ALU opcodes and
// bit positions inside the enable / busSelect control vectors.
package cpu_pkg;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SHR  = 4'd4;
   localparam logic [3:0] ALU_SHRA = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_ROR  = 4'd7;
   localparam logic [3:0] ALU_ROL  = 4'd8;
   localparam logic [3:0] ALU_NEG  = 4'd9;
   localparam logic [3:0] ALU_NOT  = 4'd10;
   localparam logic [3:0] ALU_DIV  = 4'd11;
   localparam logic [3:0] ALU_MUL  = 4'd12;

   localparam int EN_HI    = 16;
   localparam int EN_LO    = 17;
   localparam int EN_Z     = 18;
   localparam int EN_Y     = 19;
   localparam int EN_PC    = 20;
   localparam int EN_MDR   = 21;
   localparam int EN_INP   = 22;
   localparam int EN_IR    = 24;
   localparam int EN_MAR   = 25;
   localparam int EN_INCPC = 26;

   localparam int SEL_HI   = 16;
   localparam int SEL_LO   = 17;
   localparam int SEL_ZHI  = 18;
   localparam int SEL_ZLO  = 19;
   localparam int SEL_PC   = 20;
   localparam int SEL_MDR  = 21;
   localparam int SEL_INP  = 22;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   input  logic [3:0]     i_op,
   input  logic           i_incpc,
   output logic [2*W-1:0] o_result
);
   localparam int SW = $clog2(W);
   localparam logic [SW:0]  WL   = SW'(0) + W[SW:0];
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   logic [SW-1:0]  w_sh;
   logic [SW:0]    w_rsh;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   w_lo;
   logic [W-1:0]   w_hi;

   assign w_sh   = i_b[SW-1:0];
   assign w_rsh  = WL - {1'b0, w_sh};
   // sign-extend both operands so the low 2W bits of the product are the signed result
   assign w_prod = {{W{i_a[W-1]}}, i_a} * {{W{i_b[W-1]}}, i_b};

   always_comb begin
      w_lo = '0;
      w_hi = '0;
      if (i_incpc) begin
         w_lo = i_b + W'(1);
      end else begin
         case (i_op)
            ALU_SUB:  w_lo = i_a - i_b;
            ALU_AND:  w_lo = i_a & i_b;
            ALU_OR:   w_lo = i_a | i_b;
            ALU_SHR:  w_lo = i_a >> w_sh;
            ALU_SHRA: w_lo = $signed(i_a) >>> w_sh;
            ALU_SHL:  w_lo = i_a << w_sh;
            ALU_ROR:  w_lo = (i_a >> w_sh) | (i_a << w_rsh);
            ALU_ROL:  w_lo = (i_a << w_sh) | (i_a >> w_rsh);
            ALU_NEG:  w_lo = -i_b;
            ALU_NOT:  w_lo = ~i_b;
            ALU_DIV: begin
               // divide-by-zero leaves Z cleared; MIN / -1 wraps to MIN rem 0
               if (i_b == '0) begin
                  w_lo = '0;
               end else if (i_a == SMIN && i_b == '1) begin
                  w_lo = SMIN;
               end else begin
                  w_lo = $signed(i_a) / $signed(i_b);
                  w_hi = $signed(i_a) % $signed(i_b);
               end
            end
            ALU_MUL:  {w_hi, w_lo} = w_prod;
            default:  w_lo = i_a + i_b;
         endcase
      end
   end

   assign o_result = {w_hi, w_lo};
endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
// All loads and bus drivers are commanded by the external control unit.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      enable,
   input  logic [31:0]      busSelect,
   input  logic [WIDTH-1:0] inPort,
   input  logic [WIDTH-1:0] MDataIn,
   input  logic             MD_Read,
   input  logic [3:0]       Control_Signals,
   output logic [WIDTH-1:0] busMuxOut,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] mdr,
   output logic [WIDTH-1:0] zhi,
   output logic [WIDTH-1:0] zlo,
   output logic [WIDTH-1:0] pc
);
   logic [WIDTH-1:0]   r_gpr [NREGS];
   logic [WIDTH-1:0]   r_hi, r_lo, r_y, r_pc, r_ir, r_mar, r_mdr, r_inp;
   logic [2*WIDTH-1:0] r_z;

   logic [WIDTH-1:0]   w_src [32];
   logic [WIDTH-1:0]   w_bus;
   logic [2*WIDTH-1:0] w_alu;
   logic               w_unused;

   always_comb begin
      for (int i = 0; i < 32; i++) w_src[i] = '0;
      for (int i = 0; i < NREGS; i++) w_src[i] = r_gpr[i];
      w_src[SEL_HI]  = r_hi;
      w_src[SEL_LO]  = r_lo;
      w_src[SEL_ZHI] = r_z[2*WIDTH-1:WIDTH];
      w_src[SEL_ZLO] = r_z[WIDTH-1:0];
      w_src[SEL_PC]  = r_pc;
      w_src[SEL_MDR] = r_mdr;
      w_src[SEL_INP] = r_inp;
   end

   // scan from the top so the lowest asserted select is the last writer
   always_comb begin
      w_bus = '0;
      for (int i = 31; i >= 0; i--)
         if (busSelect[i]) w_bus = w_src[i];
   end

   cpu_alu #(.W(WIDTH)) u_alu (
      .i_a      (r_y),
      .i_b      (w_bus),
      .i_op     (Control_Signals),
      .i_incpc  (enable[EN_INCPC]),
      .o_result (w_alu)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_pc  <= '0;
         r_ir  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_inp <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            if (enable[i]) r_gpr[i] <= w_bus;
         if (enable[EN_HI])  r_hi  <= w_bus;
         if (enable[EN_LO])  r_lo  <= w_bus;
         if (enable[EN_Y])   r_y   <= w_bus;
         if (enable[EN_Z])   r_z   <= w_alu;
         if (enable[EN_PC])  r_pc  <= w_bus;
         if (enable[EN_IR])  r_ir  <= w_bus;
         if (enable[EN_MAR]) r_mar <= w_bus;
         if (enable[EN_MDR]) r_mdr <= MD_Read ? MDataIn : w_bus;
         if (enable[EN_INP]) r_inp <= inPort;
      end
   end

   // IR/MAR feed blocks outside this slice; reserved control bits are ignored
   assign w_unused = ^{r_ir, r_mar, enable[31:27], enable[23], busSelect[31:23]};

   assign busMuxOut = w_bus;
   assign r1  = r_gpr[1];
   assign r2  = r_gpr[2];
   assign r3  = r_gpr[3];
   assign mdr = r_mdr;
   assign zhi = r_z[2*WIDTH-1:WIDTH];
   assign zlo = r_z[WIDTH-1:0];
   assign pc  = r_pc;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;
   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] enable, busSelect, inPort, MDataIn;
   logic        MD_Read;
   logic [3:0]  Control_Signals;
   logic [31:0] busMuxOut, r1, r2, r3, mdr, zhi, zlo, pc;

   int n_chk  = 0;
   int n_fail = 0;

   cpu_datapath dut (
      .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect),
      .inPort(inPort), .MDataIn(MDataIn), .MD_Read(MD_Read),
      .Control_Signals(Control_Signals), .busMuxOut(busMuxOut),
      .r1(r1), .r2(r2), .r3(r3), .mdr(mdr), .zhi(zhi), .zlo(zlo), .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock with the given controls; returns #1 after the edge with controls idle
   task automatic cyc(input logic [31:0] en, input logic [31:0] sel, input logic [3:0] op,
                      input logic mrd, input logic [31:0] mdin);
      enable = en; busSelect = sel; Control_Signals = op; MD_Read = mrd; MDataIn = mdin;
      @(posedge clk); #1;
      enable = '0; busSelect = '0; MD_Read = 1'b0;
   endtask

   function automatic logic [31:0] b(input int n);
      logic [31:0] one;
      one = 32'd1;
      return one << n;
   endfunction

   task automatic ld_reg(input int idx, input logic [31:0] val);
      cyc(b(21), '0, 4'd0, 1'b1, val);
      cyc(b(idx), b(21), 4'd0, 1'b0, '0);
   endtask

   task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] bb,
                         input logic [3:0] op, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      ld_reg(1, a);
      ld_reg(2, bb);
      cyc(b(19), b(1), 4'd0, 1'b0, '0);
      cyc(b(18), b(2), op, 1'b0, '0);
      chk({tag, "_zhi"}, zhi, exp_hi);
      chk({tag, "_zlo"}, zlo, exp_lo);
   endtask

   initial begin
      clr = 1'b1; enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
      MD_Read = 1'b0; Control_Signals = '0;
      @(posedge clk); #1;
      clr = 1'b0;

      // load arbitrary state, then clear it
      ld_reg(1, 32'hDEAD_BEEF);
      cyc(b(20), b(21), 4'd0, 1'b0, '0);
      cyc(b(18) | b(26), b(21), 4'd0, 1'b0, '0);
      clr = 1'b1;
      cyc(b(1) | b(21), b(21), 4'd0, 1'b1, 32'h1234_5678);
      clr = 1'b0;
      chk("rst_r1", r1, 0);   chk("rst_r2", r2, 0);  chk("rst_r3", r3, 0);
      chk("rst_mdr", mdr, 0); chk("rst_zhi", zhi, 0); chk("rst_zlo", zlo, 0);
      chk("rst_pc", pc, 0);   chk("rst_bus", busMuxOut, 0);

      // MDR and register loads
      cyc(b(21), '0, 4'd0, 1'b1, 32'd2);
      chk("mdr_2", mdr, 32'd2);
      cyc(b(1), b(21), 4'd0, 1'b0, '0);
      chk("r1_2", r1, 32'd2);
      cyc(b(21), '0, 4'd0, 1'b1, 32'd4);
      cyc(b(2), b(21), 4'd0, 1'b0, '0);
      chk("r2_4", r2, 32'd4);

      // MUL 2*4, then move Z into LO/HI
      cyc(b(19), b(1), 4'd0, 1'b0, '0);
      cyc(b(18), b(2), 4'd12, 1'b0, '0);
      chk("mul_zlo", zlo, 32'd8); chk("mul_zhi", zhi, 32'd0);
      cyc(b(17), b(19), 4'd0, 1'b0, '0);
      cyc(b(16), b(18), 4'd0, 1'b0, '0);
      busSelect = b(17); #1; chk("lo_bus", busMuxOut, 32'd8);
      busSelect = b(16); #1; chk("hi_bus", busMuxOut, 32'd0);

      // lowest select wins
      busSelect = b(1) | b(2); #1; chk("prio_r1", busMuxOut, 32'd2);
      busSelect = b(2) | b(21) | b(19); #1; chk("prio_r2", busMuxOut, 32'd4);
      busSelect = '0; #1; chk("bus_none", busMuxOut, 32'd0);

      // MDR from bus path
      cyc(b(21), b(2), 4'd0, 1'b0, 32'hFFFF_FFFF);
      chk("mdr_bus", mdr, 32'd4);

      // InPort register
      inPort = 32'hCAFE_0001;
      cyc(b(22), '0, 4'd0, 1'b0, '0);
      cyc(b(3), b(22), 4'd0, 1'b0, '0);
      chk("inport_r3", r3, 32'hCAFE_0001);

      // IncPC
      cyc(b(25) | b(26) | b(18), b(20), 4'd1, 1'b0, '0);
      chk("inc_zlo", zlo, 32'd1); chk("inc_zhi", zhi, 32'd0);
      cyc(b(20), b(19), 4'd0, 1'b0, '0);
      chk("pc_1", pc, 32'd1);
      cyc(b(26) | b(18), b(20), 4'd12, 1'b0, '0);
      cyc(b(20), b(19), 4'd0, 1'b0, '0);
      chk("pc_2", pc, 32'd2);

      // ALU vectors
      alu_op("smul",  32'hFFFF_FFFE, 32'd3,         4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      alu_op("div",   32'd7,         32'd2,         4'd11, 32'd1,         32'd3);
      alu_op("divn",  32'hFFFF_FFF9, 32'd2,         4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      alu_op("div0",  32'd7,         32'd0,         4'd11, 32'd0,         32'd0);
      alu_op("divmn", 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'd0,         32'h8000_0000);
      alu_op("add",   32'hFFFF_FFFF, 32'd1,         4'd0,  32'd0,         32'd0);
      alu_op("sub",   32'd5,         32'd7,         4'd1,  32'd0,         32'hFFFF_FFFE);
      alu_op("and",   32'hF0F0_1234, 32'h0FF0_FF00, 4'd2,  32'd0,         32'h00F0_1200);
      alu_op("or",    32'hF000_0001, 32'h0000_0F00, 4'd3,  32'd0,         32'hF000_0F01);
      alu_op("shr",   32'h8000_0000, 32'd4,         4'd4,  32'd0,         32'h0800_0000);
      alu_op("shra",  32'h8000_0000, 32'd4,         4'd5,  32'd0,         32'hF800_0000);
      alu_op("shl33", 32'd1,         32'd33,        4'd6,  32'd0,         32'd2);
      alu_op("ror",   32'd1,         32'd1,         4'd7,  32'd0,         32'h8000_0000);
      alu_op("rol",   32'h8000_0001, 32'd4,         4'd8,  32'd0,         32'h0000_0018);
      alu_op("ror0",  32'h1234_5678, 32'd0,         4'd7,  32'd0,         32'h1234_5678);
      alu_op("neg",   32'd9,         32'd5,         4'd9,  32'd0,         32'hFFFF_FFFB);
      alu_op("not",   32'd9,         32'd0,         4'd10, 32'd0,         32'hFFFF_FFFF);
      alu_op("op14",  32'd3,         32'd4,         4'd14, 32'd0,         32'd7);

      // clr beats a simultaneous load
      clr = 1'b1;
      cyc(b(1) | b(20), b(2), 4'd0, 1'b0, '0);
      clr = 1'b0;
      chk("clr_r1", r1, 32'd0);
      chk("clr_pc", pc, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
